bip_control_unit: RTL

- Multi-cycle control unit for the BIP datapath: program counter, instruction register, instruction decode.
- Generates accumulator/ALU/data-RAM control strobes, including the add/sub select for the 11-bit add/sub unit.
- Run is started by the UART front-end; the block reports halt status and a cycle count back to it.

---
 rtl/bip_pkg.sv | 29 ++
 rtl/bip_decoder.sv | 57 +++++
 rtl/bip_control_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, FSM states, mux selects and ALU op.
package bip_pkg;

  localparam int unsigned OPC_HLT  = 0;
  localparam int unsigned OPC_STO  = 1;
  localparam int unsigned OPC_LD   = 2;
  localparam int unsigned OPC_LDI  = 3;
  localparam int unsigned OPC_ADD  = 4;
  localparam int unsigned OPC_ADDI = 5;
  localparam int unsigned OPC_SUB  = 6;
  localparam int unsigned OPC_SUBI = 7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decode. Outputs describe the final (accumulator/RAM-write) step of
// each instruction; needs_wb_o marks RAM-operand instructions that read in EXEC first.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int unsigned OPC_W = 5
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic [1:0]       sel_a_o,
  output logic             sel_b_o,
  output logic             op_o,
  output logic             wr_acc_o,
  output logic             rd_ram_o,
  output logic             wr_ram_o,
  output logic             needs_wb_o,
  output logic             is_halt_o
);

  always_comb begin
    sel_a_o    = SELA_RAM;
    sel_b_o    = 1'b0;
    op_o       = OP_SUB;
    wr_acc_o   = 1'b0;
    rd_ram_o   = 1'b0;
    wr_ram_o   = 1'b0;
    needs_wb_o = 1'b0;
    is_halt_o  = 1'b0;
    case (int'(opcode_i))
      OPC_HLT: is_halt_o = 1'b1;
      OPC_STO: wr_ram_o = 1'b1;
      OPC_LD: begin
        rd_ram_o   = 1'b1;
        needs_wb_o = 1'b1;
        wr_acc_o   = 1'b1;
      end
      OPC_LDI: begin
        sel_a_o  = SELA_IMM;
        wr_acc_o = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        rd_ram_o   = 1'b1;
        needs_wb_o = 1'b1;
        sel_a_o    = SELA_ALU;
        op_o       = (int'(opcode_i) == OPC_ADD) ? OP_ADD : OP_SUB;
        wr_acc_o   = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        sel_a_o  = SELA_ALU;
        sel_b_o  = 1'b1;
        op_o     = (int'(opcode_i) == OPC_ADDI) ? OP_ADD : OP_SUB;
        wr_acc_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP multi-cycle control unit: FSM, program counter, instruction register and cycle counter.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int unsigned PC_W  = 11,
  parameter int unsigned OPC_W = 5,
  parameter int unsigned OPR_W = 11,
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OPC_W+OPR_W-1:0] instr_data,
  output logic [PC_W-1:0]        instr_addr,
  output logic [OPR_W-1:0]       operand,
  output logic [1:0]             sel_a,
  output logic                   sel_b,
  output logic                   op,
  output logic                   wr_acc,
  output logic                   rd_ram,
  output logic                   wr_ram,
  output logic                   halted,
  output logic [CNT_W-1:0]       cycle_cnt
);

  state_e                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [OPC_W+OPR_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [1:0] dec_sel_a;
  logic       dec_sel_b, dec_op, dec_wr_acc, dec_rd_ram, dec_wr_ram, dec_needs_wb, dec_is_halt;

  bip_decoder #(
    .OPC_W(OPC_W)
  ) u_decoder (
    .opcode_i  (ir_q[OPR_W +: OPC_W]),
    .sel_a_o   (dec_sel_a),
    .sel_b_o   (dec_sel_b),
    .op_o      (dec_op),
    .wr_acc_o  (dec_wr_acc),
    .rd_ram_o  (dec_rd_ram),
    .wr_ram_o  (dec_wr_ram),
    .needs_wb_o(dec_needs_wb),
    .is_halt_o (dec_is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    sel_a   = SELA_RAM;
    sel_b   = 1'b0;
    op      = 1'b0;
    wr_acc  = 1'b0;
    rd_ram  = 1'b0;
    wr_ram  = 1'b0;

    // Counter runs in every active state and saturates.
    if (state_q inside {StFetch, StDecode, StExec, StWb}) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch:  state_d = StDecode;
      StDecode: begin
        ir_d    = instr_data;
        state_d = StExec;
      end
      StExec: begin
        if (dec_is_halt) begin
          state_d = StHalt;
        end else if (dec_needs_wb) begin
          rd_ram  = dec_rd_ram;
          state_d = StWb;
        end else begin
          sel_a   = dec_sel_a;
          sel_b   = dec_sel_b;
          op      = dec_op;
          wr_acc  = dec_wr_acc;
          wr_ram  = dec_wr_ram;
          pc_d    = pc_q + PC_W'(1);
          state_d = StFetch;
        end
      end
      StWb: begin
        sel_a   = dec_sel_a;
        sel_b   = dec_sel_b;
        op      = dec_op;
        wr_acc  = dec_wr_acc;
        pc_d    = pc_q + PC_W'(1);
        state_d = StFetch;
      end
      StHalt:  ;
      default: state_d = StIdle;
    endcase
  end

  assign instr_addr = pc_q;
  assign operand    = ir_q[OPR_W-1:0];
  assign halted     = (state_q == StHalt);
  assign cycle_cnt  = cnt_q;

endmodule
